bif_bctl_master_seq: RTL and testbench
======================================

Name: bif_bctl_master_seq

Overview:
- Bus-side initiator: the transmit/drive end of the BIF bus handshake whose responses (BDRY, BPERR, BLOCK) arrive through the BIF SYNC register chain.
- Takes a single-cycle start from the CPU/BCTL, arbitrates for the bus, drives BREQ/DAP/INPUT, waits for the synchronized data-ready, and reports done, parity error or timeout back to the CPU.

Parameters:
- DAP_MIN, 2: minimum OSC cycles OBDAP_n stays asserted before data-ready is accepted (1..15).
- TOUT_CYCLES, 255: cycles from OBREQ_n assertion with no data-ready before timeout (1..255); 8-bit counter.

Ports:
- OSC  input  1  system clock; all state changes on rising edge.
- MR_n  input  1  asynchronous active-low master reset.
- CSTART_n  input  1  one-cycle start pulse from BCTL, active low.
- CWRITE  input  1  cycle type, sampled with CSTART_n: 1 = write, 0 = read.
- BLOCK25_n  input  1  synchronized bus-lock; low blocks new requests.
- BGNT_n  input  1  synchronized bus grant, active low.
- BDRY50_n  input  1  synchronized responder data-ready, active low.
- BPERR50_n  input  1  synchronized parity error, active low; valid with BDRY50_n.
- OBREQ_n  output  1  bus request driver.
- OBDAP_n  output  1  data/address-present driver.
- OBINPUT_n  output  1  low during read cycles while OBDAP_n is low.
- CBUSY_n  output  1  low from accepted start until return to IDLE.
- CDONE_n  output  1  one-cycle completion pulse.
- CPERR_n  output  1  one-cycle parity-error pulse, coincident with CDONE_n.
- CTOUT_n  output  1  one-cycle timeout pulse.

Behaviour:
- Reset (MR_n low, asynchronous): state IDLE, all outputs 1, counter 0, pending 0.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - CSTART_n low sets pending and latches CWRITE; CBUSY_n goes low next cycle.
  - Pending with BLOCK25_n high moves to REQ; OBREQ_n goes low on that edge.
  - Pending with BLOCK25_n low holds in IDLE with CBUSY_n low.
- CSTART_n while CBUSY_n is low: ignored, no queueing.
- REQ: on BGNT_n low, go to ADDR.
  - OBDAP_n goes low.
  - OBINPUT_n = CWRITE_latched (0 for read).
  - DAP counter loads DAP_MIN-1.
- ADDR: count down the DAP counter; at 0, go to WAIT.
  - BDRY50_n is ignored here.
- WAIT: on BDRY50_n low, go to RELEASE.
  - OBREQ_n, OBDAP_n and OBINPUT_n go to 1.
  - CDONE_n pulses low for 1 cycle.
  - CPERR_n = BPERR50_n sampled on the same edge, 1-cycle pulse.
- RELEASE: wait for BDRY50_n high, then go to IDLE; CBUSY_n goes to 1 on that edge.
- Grant removal: BGNT_n going high after ADDR entry is ignored.
- Timeout:
  - Counter clears on the edge entering REQ and increments every cycle in REQ, ADDR and WAIT.
  - When it reaches TOUT_CYCLES without a BDRY accept: drive all bus outputs to 1, pulse CTOUT_n for 1 cycle, go to RELEASE.
  - If BDRY50_n goes low on the same cycle the count reaches TOUT_CYCLES, completion wins: CDONE_n pulses, CTOUT_n stays 1.
- Counter saturates; it never wraps.
- Latency, start to bus: CSTART_n low at edge N gives CBUSY_n low at N+1 and OBREQ_n low at N+1 when BLOCK25_n is high.
- Latency, data-ready to done: CDONE_n low on the edge after BDRY50_n is sampled low in WAIT.
- Reset mid-cycle: bus drivers release immediately (asynchronous) and no done/error pulse is issued.

Optional Feature:
- Macro BIF_PERR_RETRY_EN.
- Defined:
  - A BPERR50_n-low completion on the first attempt suppresses CDONE_n/CPERR_n.
  - The block passes through RELEASE, then re-enters REQ once (CBUSY_n stays low) with the same CWRITE.
  - The second attempt reports normally, including CPERR_n if it fails again.
  - A retry counter (1 bit) clears on each accepted start.
- Undefined: no retry; parity error is reported on the first completion.

Test Plan:
- Read, no errors, DAP_MIN=2:
  - Stimulus: CSTART_n low 1 cycle, CWRITE=0; BGNT_n low 2 cycles later; BDRY50_n low 5 cycles later.
  - Expect: OBINPUT_n low with OBDAP_n, DAP held ≥2 cycles, CDONE_n single pulse, CPERR_n=1, CBUSY_n high after BDRY50_n released.
- Lock hold-off: BLOCK25_n low for 10 cycles around a start -> OBREQ_n stays 1 and CBUSY_n is low, then OBREQ_n asserts the cycle after BLOCK25_n rises.
- Timeout, TOUT_CYCLES=20: grant given, BDRY50_n never asserted -> CTOUT_n pulses 20 cycles after OBREQ_n fell, bus outputs go to 1, then IDLE.
- Parity error, write cycle:
  - Stimulus: BDRY50_n and BPERR50_n low together.
  - Expect without the macro: CDONE_n and CPERR_n pulse on the same cycle.
  - Expect with BIF_PERR_RETRY_EN: a second OBREQ_n sequence runs, and the done pulse follows only the second BDRY.
- Early BDRY: BDRY50_n already low when ADDR is entered -> not accepted until DAP_MIN has elapsed, then CDONE_n pulses.
- Async reset in WAIT: MR_n low mid-cycle -> OBREQ_n, OBDAP_n and CBUSY_n go to 1 without waiting for an OSC edge, and no CDONE_n/CTOUT_n pulse follows release of reset.

Source files
------------

// File: rtl/bif_bctl_master_seq.sv
`default_nettype none
// ============================================================================
// Module   : bif_bctl_master_seq
// Purpose  : BIF bus initiator: start -> request/grant -> DAP -> data-ready,
//            reporting done, parity error or timeout back to the CPU/BCTL.
// Option   : define BIF_PERR_RETRY_EN to retry once after a parity error.
// Revision : 1.0
// ============================================================================
module bif_bctl_master_seq #(
  parameter int DAP_MIN     = 2,
  parameter int TOUT_CYCLES = 255
) (
  input  logic OSC,
  input  logic MR_n,
  input  logic CSTART_n,
  input  logic CWRITE,
  input  logic BLOCK25_n,
  input  logic BGNT_n,
  input  logic BDRY50_n,
  input  logic BPERR50_n,
  output logic OBREQ_n,
  output logic OBDAP_n,
  output logic OBINPUT_n,
  output logic CBUSY_n,
  output logic CDONE_n,
  output logic CPERR_n,
  output logic CTOUT_n
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_ADDR    = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  localparam logic [3:0] DAP_LOAD  = 4'(DAP_MIN - 1);
  localparam logic [7:0] TOUT_LAST = 8'(TOUT_CYCLES - 1);

  state_e     state_q;
  logic [7:0] tout_cnt_q, tout_cnt_d;
  logic [3:0] dap_cnt_q;
  logic       pending_q, cwrite_q;
  logic       obreq_n_q, obdap_n_q, obinput_n_q;
  logic       cbusy_n_q, cdone_n_q, cperr_n_q, ctout_n_q;
`ifdef BIF_PERR_RETRY_EN
  logic       retry_q, again_q;
`endif

  logic start_acc, active, accept, tout_hit;

  always_comb begin
    tout_cnt_d = (tout_cnt_q == 8'hFF) ? tout_cnt_q : tout_cnt_q + 8'd1;
    // CBUSY_n high implies IDLE with nothing pending, so starts are only taken then.
    start_acc  = !CSTART_n && cbusy_n_q;
    active     = (state_q == S_REQ) || (state_q == S_ADDR) || (state_q == S_WAIT);
    accept     = (state_q == S_WAIT) && !BDRY50_n;
    tout_hit   = (tout_cnt_q >= TOUT_LAST);
  end

  always_ff @(posedge OSC or negedge MR_n) begin
    if (!MR_n) begin
      state_q     <= S_IDLE;
      tout_cnt_q  <= 8'd0;
      dap_cnt_q   <= 4'd0;
      pending_q   <= 1'b0;
      cwrite_q    <= 1'b0;
      obreq_n_q   <= 1'b1;
      obdap_n_q   <= 1'b1;
      obinput_n_q <= 1'b1;
      cbusy_n_q   <= 1'b1;
      cdone_n_q   <= 1'b1;
      cperr_n_q   <= 1'b1;
      ctout_n_q   <= 1'b1;
`ifdef BIF_PERR_RETRY_EN
      retry_q     <= 1'b0;
      again_q     <= 1'b0;
`endif
    end else begin
      cdone_n_q <= 1'b1;
      cperr_n_q <= 1'b1;
      ctout_n_q <= 1'b1;
      if (active) tout_cnt_q <= tout_cnt_d;

      // A data-ready accepted on the terminal count beats the timeout.
      if (active && tout_hit && !accept) begin
        obreq_n_q   <= 1'b1;
        obdap_n_q   <= 1'b1;
        obinput_n_q <= 1'b1;
        ctout_n_q   <= 1'b0;
        state_q     <= S_RELEASE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_acc) begin
              cwrite_q  <= CWRITE;
              cbusy_n_q <= 1'b0;
              pending_q <= 1'b1;
`ifdef BIF_PERR_RETRY_EN
              retry_q   <= 1'b0;
              again_q   <= 1'b0;
`endif
            end
            if ((start_acc || pending_q) && BLOCK25_n) begin
              pending_q  <= 1'b0;
              tout_cnt_q <= 8'd0;
              obreq_n_q  <= 1'b0;
              state_q    <= S_REQ;
            end
          end
          S_REQ: begin
            if (!BGNT_n) begin
              obdap_n_q   <= 1'b0;
              obinput_n_q <= cwrite_q;
              dap_cnt_q   <= DAP_LOAD;
              state_q     <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (dap_cnt_q == 4'd0) state_q <= S_WAIT;
            else dap_cnt_q <= dap_cnt_q - 4'd1;
          end
          S_WAIT: begin
            if (accept) begin
              obreq_n_q   <= 1'b1;
              obdap_n_q   <= 1'b1;
              obinput_n_q <= 1'b1;
              state_q     <= S_RELEASE;
`ifdef BIF_PERR_RETRY_EN
              if (!BPERR50_n && !retry_q) begin
                retry_q <= 1'b1;
                again_q <= 1'b1;
              end else begin
                cdone_n_q <= 1'b0;
                cperr_n_q <= BPERR50_n;
              end
`else
              cdone_n_q <= 1'b0;
              cperr_n_q <= BPERR50_n;
`endif
            end
          end
          S_RELEASE: begin
            if (BDRY50_n) begin
`ifdef BIF_PERR_RETRY_EN
              if (again_q) begin
                again_q    <= 1'b0;
                tout_cnt_q <= 8'd0;
                obreq_n_q  <= 1'b0;
                state_q    <= S_REQ;
              end else begin
                cbusy_n_q <= 1'b1;
                state_q   <= S_IDLE;
              end
`else
              cbusy_n_q <= 1'b1;
              state_q   <= S_IDLE;
`endif
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign OBREQ_n   = obreq_n_q;
  assign OBDAP_n   = obdap_n_q;
  assign OBINPUT_n = obinput_n_q;
  assign CBUSY_n   = cbusy_n_q;
  assign CDONE_n   = cdone_n_q;
  assign CPERR_n   = cperr_n_q;
  assign CTOUT_n   = ctout_n_q;

endmodule
`default_nettype wire

// File: tb/tb_bif_bctl_master_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bif_bctl_master_seq
// Purpose  : Directed self-checking bench for bif_bctl_master_seq.
// Revision : 1.0
// ============================================================================
module tb_bif_bctl_master_seq;

  logic OSC = 1'b0;
  logic MR_n, CSTART_n, CWRITE, BLOCK25_n, BGNT_n, BDRY50_n, BPERR50_n;
  logic OBREQ_n, OBDAP_n, OBINPUT_n, CBUSY_n, CDONE_n, CPERR_n, CTOUT_n;
  logic [6:0] outs;

  int n_pass  = 0;
  int n_total = 0;

  always #5 OSC = ~OSC;

  // {OBREQ_n, OBDAP_n, OBINPUT_n, CBUSY_n, CDONE_n, CPERR_n, CTOUT_n}
  assign outs = {OBREQ_n, OBDAP_n, OBINPUT_n, CBUSY_n, CDONE_n, CPERR_n, CTOUT_n};

  bif_bctl_master_seq #(
    .DAP_MIN     (2),
    .TOUT_CYCLES (20)
  ) u_dut (
    .OSC       (OSC),
    .MR_n      (MR_n),
    .CSTART_n  (CSTART_n),
    .CWRITE    (CWRITE),
    .BLOCK25_n (BLOCK25_n),
    .BGNT_n    (BGNT_n),
    .BDRY50_n  (BDRY50_n),
    .BPERR50_n (BPERR50_n),
    .OBREQ_n   (OBREQ_n),
    .OBDAP_n   (OBDAP_n),
    .OBINPUT_n (OBINPUT_n),
    .CBUSY_n   (CBUSY_n),
    .CDONE_n   (CDONE_n),
    .CPERR_n   (CPERR_n),
    .CTOUT_n   (CTOUT_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge OSC);
      #1;
    end
  endtask

  task automatic start_cycle(input logic wr);
    CSTART_n = 1'b0;
    CWRITE   = wr;
    step();
    CSTART_n = 1'b1;
  endtask

  initial begin
    int   cyc;
    logic seen;
    logic quiet;

    MR_n = 1'b0; CSTART_n = 1'b1; CWRITE = 1'b0; BLOCK25_n = 1'b1;
    BGNT_n = 1'b1; BDRY50_n = 1'b1; BPERR50_n = 1'b1;
    step(2);
    check_eq("reset_outs", 32'(outs), 32'h7F);
    MR_n = 1'b1;
    step(2);

    // Read, no errors
    start_cycle(1'b0);
    check_eq("rd_start", 32'(outs), 32'h37);
    step();
    BGNT_n = 1'b0;
    step();
    check_eq("rd_addr", 32'(outs), 32'h07);
    step();
    check_eq("rd_dap_hold", 32'(outs), 32'h07);
    step();
    check_eq("rd_wait", 32'(outs), 32'h07);
    BDRY50_n = 1'b0;
    step();
    check_eq("rd_done", 32'(outs), 32'h73);
    BGNT_n = 1'b1;
    step();
    check_eq("rd_release", 32'(outs), 32'h77);
    BDRY50_n = 1'b1;
    step();
    check_eq("rd_idle", 32'(outs), 32'h7F);

    // Lock hold-off followed by a write with a parity error
    BLOCK25_n = 1'b0;
    step(3);
    start_cycle(1'b1);
    check_eq("lock_busy", 32'(outs), 32'h77);
    step(5);
    check_eq("lock_hold", 32'(outs), 32'h77);
    BLOCK25_n = 1'b1;
    step();
    check_eq("lock_req", 32'(outs), 32'h37);
    BGNT_n = 1'b0;
    step();
    check_eq("wr_addr", 32'(outs), 32'h17);
    step(2);
    BDRY50_n = 1'b0; BPERR50_n = 1'b0;
    step();
`ifdef BIF_PERR_RETRY_EN
    check_eq("perr_suppressed", 32'(outs), 32'h77);
    BDRY50_n = 1'b1; BPERR50_n = 1'b1;
    step();
    check_eq("retry_req", 32'(outs), 32'h37);
    step();
    check_eq("retry_addr", 32'(outs), 32'h17);
    step(2);
    BDRY50_n = 1'b0; BPERR50_n = 1'b0;
    step();
`endif
    check_eq("perr_done", 32'(outs), 32'h71);
    BDRY50_n = 1'b1; BPERR50_n = 1'b1; BGNT_n = 1'b1;
    step();
    check_eq("perr_idle", 32'(outs), 32'h7F);

    // Timeout: grant given, no data-ready
    start_cycle(1'b0);
    BGNT_n = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      step();
      cyc++;
      if (!CTOUT_n) seen = 1'b1;
    end
    check_eq("tout_latency", 32'(cyc), 32'd20);
    check_eq("tout_outs", 32'(outs), 32'h76);
    BGNT_n = 1'b1;
    step();
    check_eq("tout_idle", 32'(outs), 32'h7F);

    // Early data-ready: ignored until the DAP minimum elapses
    start_cycle(1'b0);
    BGNT_n = 1'b0; BDRY50_n = 1'b0;
    step();
    check_eq("early_addr", 32'(outs), 32'h07);
    step();
    check_eq("early_hold", 32'(outs), 32'h07);
    step();
    check_eq("early_wait", 32'(outs), 32'h07);
    step();
    check_eq("early_done", 32'(outs), 32'h73);
    BDRY50_n = 1'b1; BGNT_n = 1'b1;
    step();
    check_eq("early_idle", 32'(outs), 32'h7F);

    // Data-ready on the terminal count: completion wins
    start_cycle(1'b0);
    BGNT_n = 1'b0;
    step(19);
    check_eq("edge_pre", 32'(outs), 32'h07);
    BDRY50_n = 1'b0;
    step();
    check_eq("edge_done_wins", 32'(outs), 32'h73);
    BDRY50_n = 1'b1; BGNT_n = 1'b1;
    step();
    check_eq("edge_idle", 32'(outs), 32'h7F);

    // Asynchronous reset while waiting for data-ready
    start_cycle(1'b0);
    BGNT_n = 1'b0;
    step(3);
    check_eq("rst_pre_wait", 32'(outs), 32'h07);
    #3 MR_n = 1'b0;
    #1;
    check_eq("rst_async", 32'(outs), 32'h7F);
    step(2);
    MR_n = 1'b1;
    BDRY50_n = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      quiet = quiet & CDONE_n & CTOUT_n;
    end
    check_eq("rst_no_pulse", 32'(quiet), 32'd1);
    check_eq("rst_idle", 32'(outs), 32'h7F);
    BDRY50_n = 1'b1; BGNT_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
